sdram_port_arbiter: RTL

SDRAM_PORT_ARBITER -- requirements
Module: sdram_port_arbiter

---
 rtl/sdram_port_arbiter_if.sv | 40 ++++
 rtl/sdram_port_arbiter.sv | 128 ++++++++++++
 2 files changed

// File: rtl/sdram_port_arbiter_if.sv
// Requester-side and SDRAM-controller-side signals of the port arbiter.
// The arbiter takes the slave view; the requester/controller side takes master.
interface sdram_port_arbiter_if #(
  parameter int N_PORTS = 4,
  parameter int ADDR_W  = 24,
  parameter int DATA_W  = 16
);
  localparam int GW = $clog2(N_PORTS);

  logic [N_PORTS-1:0]        port_call;
  logic [N_PORTS-1:0]        port_we;
  logic [N_PORTS*ADDR_W-1:0] port_addr;
  logic [N_PORTS*DATA_W-1:0] port_wdata;
  logic [N_PORTS-1:0]        port_done;
  logic                      port_err;
  logic [DATA_W-1:0]         port_rdata;
  logic [1:0]                mem_call;
  logic [ADDR_W-1:0]         mem_addr;
  logic [DATA_W-1:0]         mem_wdata;
  logic [1:0]                mem_done;
  logic [DATA_W-1:0]         mem_rdata;
  logic                      busy;
  logic [GW-1:0]             grant_id;

  modport slave (
    input  port_call, port_we, port_addr, port_wdata,
    input  mem_done, mem_rdata,
    output port_done, port_err, port_rdata,
    output mem_call, mem_addr, mem_wdata,
    output busy, grant_id
  );

  modport master (
    output port_call, port_we, port_addr, port_wdata,
    output mem_done, mem_rdata,
    input  port_done, port_err, port_rdata,
    input  mem_call, mem_addr, mem_wdata,
    input  busy, grant_id
  );
endinterface

// File: rtl/sdram_port_arbiter.sv
// N-port arbiter in front of a single SDRAM controller.
// Fixed or round-robin grant, one access at a time, with a wait timeout.
module sdram_port_arbiter #(
  parameter int N_PORTS = 4,
  parameter int ADDR_W  = 24,
  parameter int DATA_W  = 16,
  parameter int RR_MODE = 0,
  parameter int TIMEOUT = 1023
) (
  input logic clk,
  input logic rst,
  sdram_port_arbiter_if.slave bus
);
  localparam int GW = $clog2(N_PORTS);
  localparam int CW = $clog2(TIMEOUT + 1);

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

  state_t              state_q;
  logic [GW-1:0]       win_q;
  logic                we_q;
  logic [ADDR_W-1:0]   addr_q;
  logic [DATA_W-1:0]   wdata_q;
  logic [1:0]          mem_call_q;
  logic [N_PORTS-1:0]  done_q;
  logic                err_q;
  logic [DATA_W-1:0]   rdata_q;
  logic                busy_q;
  logic [GW-1:0]       ptr_q;
  logic [CW-1:0]       wait_q;
  logic [N_PORTS-1:0]  mask_q;

  logic [N_PORTS-1:0]  req;
  logic                found_d;
  logic [GW-1:0]       win_d;
  logic [GW-1:0]       ptr_d;
  logic                hit;
  logic [N_PORTS-1:0]  win_oh;
  int                  j;

  // Served port is masked for one IDLE cycle so a lingering call is not re-granted
  assign req    = bus.port_call & ~mask_q;
  assign hit    = we_q ? bus.mem_done[1] : bus.mem_done[0];
  assign win_oh = {{(N_PORTS-1){1'b0}}, 1'b1} << win_q;

  always_comb begin
    found_d = 1'b0;
    win_d   = '0;
    j       = 0;
    for (int k = 0; k < N_PORTS; k++) begin
      j = (RR_MODE != 0) ? int'(ptr_q) + k : k;
      if (j >= N_PORTS) j = j - N_PORTS;
      if (!found_d && req[GW'(j)]) begin
        found_d = 1'b1;
        win_d   = GW'(j);
      end
    end
  end

  assign ptr_d = (win_d == GW'(N_PORTS - 1)) ? '0 : win_d + 1'b1;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      win_q      <= '0;
      we_q       <= 1'b0;
      addr_q     <= '0;
      wdata_q    <= '0;
      mem_call_q <= '0;
      done_q     <= '0;
      err_q      <= 1'b0;
      rdata_q    <= '0;
      busy_q     <= 1'b0;
      ptr_q      <= '0;
      wait_q     <= '0;
      mask_q     <= '0;
    end else begin
      done_q <= '0;
      err_q  <= 1'b0;
      unique case (state_q)
        IDLE: begin
          mask_q <= '0;
          if (found_d) begin
            state_q    <= BUSY;
            win_q      <= win_d;
            we_q       <= bus.port_we[win_d];
            addr_q     <= bus.port_addr[int'(win_d)*ADDR_W +: ADDR_W];
            wdata_q    <= bus.port_wdata[int'(win_d)*DATA_W +: DATA_W];
            mem_call_q <= {bus.port_we[win_d], ~bus.port_we[win_d]};
            busy_q     <= 1'b1;
            wait_q     <= '0;
            ptr_q      <= ptr_d;
          end
        end
        BUSY: begin
          if (hit) begin
            mem_call_q <= '0;
            if (!we_q) rdata_q <= bus.mem_rdata;
            done_q     <= win_oh;
            state_q    <= DONE;
          end else if (wait_q == CW'(TIMEOUT - 1)) begin
            mem_call_q <= '0;
            done_q     <= win_oh;
            err_q      <= 1'b1;
            state_q    <= DONE;
          end else begin
            wait_q <= wait_q + 1'b1;
          end
        end
        DONE: begin
          state_q <= IDLE;
          busy_q  <= 1'b0;
          mask_q  <= win_oh;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign bus.port_done  = done_q;
  assign bus.port_err   = err_q;
  assign bus.port_rdata = rdata_q;
  assign bus.mem_call   = mem_call_q;
  assign bus.mem_addr   = addr_q;
  assign bus.mem_wdata  = wdata_q;
  assign bus.busy       = busy_q;
  assign bus.grant_id   = win_q;
endmodule
